// File: rtl/gpio_in_pkg.sv
// Shared constants and bus request type for the GPIO input-conditioning stage.
package gpio_in_pkg;

    localparam int ADDR_W    = 5;
    localparam int LIMIT_RST = 1000;

    localparam logic [ADDR_W-1:0] OFS_LIMIT = 5'h00;
    localparam logic [ADDR_W-1:0] OFS_IRQEN = 5'h04;
    localparam logic [ADDR_W-1:0] OFS_EDGE  = 5'h08;
    localparam logic [ADDR_W-1:0] OFS_RAW   = 5'h0C;
    localparam logic [ADDR_W-1:0] OFS_FALL  = 5'h10;

    typedef struct packed {
        logic              sel;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
    } bus_req_t;

    function automatic logic wr_hit(input bus_req_t req, input logic [ADDR_W-1:0] ofs);
        return req.sel & req.wr & (req.addr == ofs);
    endfunction

endpackage

// File: rtl/gpio_db_bit.sv
// One conditioned input bit: synchroniser chain, 2-bit stability counter and clean flop.
module gpio_db_bit
    import gpio_in_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pad,
    input  logic tick,
    input  logic bypass,
    input  logic clr_cnt,
    output logic sync,
    output logic clean
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0]             cnt_q, cnt_d;
    logic                   clean_q, clean_d;

    assign sync  = sync_q[SYNC_STAGES-1];
    assign clean = clean_q;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], pad};
        cnt_d   = cnt_q;
        clean_d = clean_q;
        if (bypass) begin
            clean_d = sync;
            cnt_d   = 2'd0;
        end else if (clr_cnt) begin
            cnt_d = 2'd0;
        end else if (tick) begin
            // The counter never holds 3: the third disagreeing tick accepts and clears.
            if (sync != clean_q) begin
                if (cnt_q == 2'd2) begin
                    clean_d = sync;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end else begin
                cnt_d = 2'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            cnt_q   <= 2'd0;
            clean_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

endmodule

// File: rtl/gpio_in_cond.sv
// GPIO input conditioning: sync, debounce, rising-edge capture, level irq, bus registers.
// Define GPIO_IN_BOTH_EDGE_EN to add the FALLEDGE register at 0x10 and include it in irq.
module gpio_in_cond
    import gpio_in_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DB_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      bAddr,
    input  logic [31:0]      bWData,
    input  logic             bSel,
    input  logic             bWrite,
    output logic [31:0]      bRData,
    input  logic [WIDTH-1:0] padIn,
    output logic [WIDTH-1:0] gpioClean,
    output logic             irq
);

    localparam int WD_HI = (WIDTH > DB_W) ? WIDTH : DB_W;

    bus_req_t req;
    assign req = '{sel: bSel, wr: bWrite, addr: bAddr[ADDR_W-1:0], wdata: bWData};

    logic unused_bits;
    assign unused_bits = ^{bAddr[31:ADDR_W], bWData[31:WD_HI]};

    logic wr_limit, wr_irqen, wr_edge;
    assign wr_limit = wr_hit(req, OFS_LIMIT);
    assign wr_irqen = wr_hit(req, OFS_IRQEN);
    assign wr_edge  = wr_hit(req, OFS_EDGE);

    logic [DB_W-1:0]  limit_q, limit_d;
    logic [DB_W-1:0]  presc_q, presc_d;
    logic [WIDTH-1:0] irqen_q, irqen_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] cln_dly_q;
    logic             irq_q, irq_d;
    logic [WIDTH-1:0] raw, rise;
    logic             tick, bypass;

    assign bypass = (limit_q == '0);
    assign tick   = !bypass && (presc_q == limit_q);
    assign rise   = gpioClean & ~cln_dly_q;
    assign irq    = irq_q;

    gpio_db_bit #(.SYNC_STAGES(SYNC_STAGES)) u_db [WIDTH-1:0] (
        .clk    (clk),
        .rst_n  (rst),
        .pad    (padIn),
        .tick   (tick),
        .bypass (bypass),
        .clr_cnt(wr_limit),
        .sync   (raw),
        .clean  (gpioClean)
    );

`ifdef GPIO_IN_BOTH_EDGE_EN
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] fall;
    logic             wr_fall;
    assign fall    = ~gpioClean & cln_dly_q;
    assign wr_fall = wr_hit(req, OFS_FALL);
`endif

    always_comb begin
        limit_d = limit_q;
        irqen_d = irqen_q;
        presc_d = presc_q + DB_W'(1);
        if (wr_limit) limit_d = req.wdata[DB_W-1:0];
        if (wr_irqen) irqen_d = req.wdata[WIDTH-1:0];
        // Prescaler wraps on equality, so LIMIT = all-ones never overflows.
        if (wr_limit || bypass || tick) presc_d = '0;
        // Set is OR'd in after the clear, so a coincident rising edge survives.
        edge_d = (edge_q & ~(wr_edge ? req.wdata[WIDTH-1:0] : '0)) | rise;
`ifdef GPIO_IN_BOTH_EDGE_EN
        fall_d = (fall_q & ~(wr_fall ? req.wdata[WIDTH-1:0] : '0)) | fall;
        irq_d  = |((edge_q | fall_q) & irqen_q);
`else
        irq_d  = |(edge_q & irqen_q);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            limit_q   <= DB_W'(LIMIT_RST);
            presc_q   <= '0;
            irqen_q   <= '0;
            edge_q    <= '0;
            cln_dly_q <= '0;
            irq_q     <= 1'b0;
        end else begin
            limit_q   <= limit_d;
            presc_q   <= presc_d;
            irqen_q   <= irqen_d;
            edge_q    <= edge_d;
            cln_dly_q <= gpioClean;
            irq_q     <= irq_d;
        end
    end

`ifdef GPIO_IN_BOTH_EDGE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) fall_q <= '0;
        else      fall_q <= fall_d;
    end
`endif

    // Bit 4 is decoded in both builds so that 0x10 never aliases LIMIT.
    always_comb begin
        bRData = '0;
        case (req.addr)
            OFS_LIMIT: bRData = 32'(limit_q);
            OFS_IRQEN: bRData = 32'(irqen_q);
            OFS_EDGE:  bRData = 32'(edge_q);
            OFS_RAW:   bRData = 32'(raw);
`ifdef GPIO_IN_BOTH_EDGE_EN
            OFS_FALL:  bRData = 32'(fall_q);
`endif
            default:   bRData = '0;
        endcase
    end

endmodule

// File: tb/tb_gpio_in_cond.sv
// Directed bench for gpio_in_cond: reset, bypass latency, debounce, W1C, LIMIT rewrite, async reset.
`timescale 1ns/1ps
module tb_gpio_in_cond;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] bAddr = '0, bWData = '0, bRData;
    logic        bSel = 1'b0, bWrite = 1'b0;
    logic [15:0] padIn = '0, gpioClean;
    logic        irq;

    int vectors = 0;
    int errors  = 0;

    gpio_in_cond #(.WIDTH(16), .SYNC_STAGES(2), .DB_W(16)) dut (
        .clk(clk), .rst(rst), .bAddr(bAddr), .bWData(bWData), .bSel(bSel),
        .bWrite(bWrite), .bRData(bRData), .padIn(padIn), .gpioClean(gpioClean), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        bAddr = a; bWData = d; bSel = 1'b1; bWrite = 1'b1;
        @(posedge clk);
        #1;
        bSel = 1'b0; bWrite = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        bAddr = a; bSel = 1'b1; bWrite = 1'b0;
        #1;
        d = bRData;
        bSel = 1'b0;
    endtask

    task automatic apply_reset();
        padIn = '0; bSel = 1'b0; bWrite = 1'b0;
        rst = 1'b0;
        step(2);
        rst = 1'b1;
        step(1);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        apply_reset();
        bus_rd(32'h0, d);
        vectors++; if (d !== 32'd1000) begin errors++; $display("FAIL rst_limit got %h exp %h", d, 32'd1000); end
        bus_rd(32'h4, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL rst_irqen got %h exp 0", d); end
        bus_rd(32'h8, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL rst_edge got %h exp 0", d); end
        step(1);
        bus_rd(32'hC, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL rst_raw got %h exp 0", d); end
        vectors++; if (gpioClean !== 16'h0) begin errors++; $display("FAIL rst_clean got %h exp 0", gpioClean); end
        vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq got %b exp 0", irq); end
        step(1);
    endtask

    task automatic test_bypass();
        logic [31:0] d;
        bus_wr(32'h0, 32'h0);
        padIn = 16'h0001;
        step(2);
        vectors++; if (gpioClean !== 16'h0000) begin errors++; $display("FAIL byp_early got %h exp 0000", gpioClean); end
        bus_rd(32'hC, d);
        vectors++; if (d !== 32'h1) begin errors++; $display("FAIL byp_raw got %h exp 1", d); end
        step(1);
        vectors++; if (gpioClean !== 16'h0001) begin errors++; $display("FAIL byp_lat3 got %h exp 0001", gpioClean); end
        bus_rd(32'h8, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL byp_edge_pre got %h exp 0", d); end
        step(1);
        bus_rd(32'h8, d);
        vectors++; if (d !== 32'h1) begin errors++; $display("FAIL byp_edge got %h exp 1", d); end
    endtask

    task automatic test_irq();
        bus_wr(32'h4, 32'h1);
        vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_pre got %b exp 0", irq); end
        step(1);
        vectors++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", irq); end
    endtask

    task automatic test_debounce();
        logic [31:0] d;
        int n;
        apply_reset();
        bus_wr(32'h0, 32'd4);
        padIn = 16'h0008;
        step(8);
        padIn = 16'h0000;
        step(20);
        vectors++; if (gpioClean !== 16'h0) begin errors++; $display("FAIL db_glitch got %h exp 0", gpioClean); end
        bus_rd(32'h8, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL db_glitch_edge got %h exp 0", d); end
        padIn = 16'h0008;
        n = 0;
        while (n < 20 && gpioClean[3] !== 1'b1) begin
            step(1);
            n++;
        end
        vectors++;
        if (gpioClean !== 16'h0008 || n < 13 || n > 18) begin
            errors++; $display("FAIL db_accept clean %h after %0d cycles exp 0008 within 13..18", gpioClean, n);
        end
    endtask

    task automatic test_w1c();
        logic [31:0] d;
        apply_reset();
        bus_wr(32'h0, 32'h0);
        padIn = 16'h0003;
        step(5);
        bus_rd(32'h8, d);
        vectors++; if (d !== 32'h3) begin errors++; $display("FAIL w1c_init got %h exp 3", d); end
        bus_wr(32'h4, 32'h2);
        step(1);
        vectors++; if (irq !== 1'b1) begin errors++; $display("FAIL w1c_irq_on got %b exp 1", irq); end
        bus_wr(32'h8, 32'h2);
        bus_rd(32'h8, d);
        vectors++; if (d !== 32'h1) begin errors++; $display("FAIL w1c_clear got %h exp 1", d); end
        step(1);
        vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq_off got %b exp 0", irq); end
        padIn = 16'h0001;
        step(4);
        padIn = 16'h0003;
        step(3);
        bus_wr(32'h8, 32'h2);
        bus_rd(32'h8, d);
        vectors++; if (d !== 32'h3) begin errors++; $display("FAIL w1c_set_wins got %h exp 3", d); end
        step(1);
        vectors++; if (irq !== 1'b1) begin errors++; $display("FAIL w1c_irq_again got %b exp 1", irq); end
    endtask

    task automatic test_limit_rewrite();
        apply_reset();
        bus_wr(32'h0, 32'd4);
        padIn = 16'h0008;
        step(10);
        bus_wr(32'h0, 32'd4);
        step(4);
        vectors++; if (gpioClean !== 16'h0) begin errors++; $display("FAIL lim_old_tick got %h exp 0", gpioClean); end
        step(10);
        vectors++; if (gpioClean !== 16'h0) begin errors++; $display("FAIL lim_two_new got %h exp 0", gpioClean); end
        step(1);
        vectors++; if (gpioClean !== 16'h0008) begin errors++; $display("FAIL lim_third_new got %h exp 0008", gpioClean); end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        bus_wr(32'h4, 32'h8);
        step(2);
        vectors++; if (irq !== 1'b1) begin errors++; $display("FAIL ar_pre_irq got %b exp 1", irq); end
        #2;
        rst = 1'b0;
        #1;
        vectors++; if (gpioClean !== 16'h0) begin errors++; $display("FAIL ar_clean got %h exp 0", gpioClean); end
        vectors++; if (irq !== 1'b0) begin errors++; $display("FAIL ar_irq got %b exp 0", irq); end
        bus_rd(32'h0, d);
        vectors++; if (d !== 32'd1000) begin errors++; $display("FAIL ar_limit got %h exp %h", d, 32'd1000); end
        bus_rd(32'h4, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL ar_irqen got %h exp 0", d); end
        bus_rd(32'h8, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL ar_edge got %h exp 0", d); end
        bus_rd(32'hC, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL ar_raw got %h exp 0", d); end
        step(1);
        rst = 1'b1;
        step(1);
    endtask

`ifdef GPIO_IN_BOTH_EDGE_EN
    task automatic test_fall();
        logic [31:0] d;
        apply_reset();
        bus_wr(32'h0, 32'h0);
        padIn = 16'h0020;
        step(5);
        bus_wr(32'h8, 32'hFFFF);
        bus_rd(32'h8, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL fall_edge_clr got %h exp 0", d); end
        padIn = 16'h0000;
        step(5);
        bus_rd(32'h10, d);
        vectors++; if (d !== 32'h20) begin errors++; $display("FAIL fall_reg got %h exp 20", d); end
        bus_rd(32'h8, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL fall_edge_kept got %h exp 0", d); end
        bus_wr(32'h4, 32'h20);
        step(1);
        vectors++; if (irq !== 1'b1) begin errors++; $display("FAIL fall_irq got %b exp 1", irq); end
    endtask
`else
    task automatic test_fall();
        logic [31:0] d;
        apply_reset();
        bus_wr(32'h0, 32'h0);
        padIn = 16'h0020;
        step(5);
        padIn = 16'h0000;
        step(5);
        bus_rd(32'h10, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL ofs10_unmapped got %h exp 0", d); end
        bus_wr(32'h10, 32'h5);
        bus_rd(32'h0, d);
        vectors++; if (d !== 32'h0) begin errors++; $display("FAIL ofs10_wr_ignored got %h exp 0", d); end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_bypass();
        test_irq();
        test_debounce();
        test_w1c();
        test_limit_rewrite();
        test_async_reset();
        test_fall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
